// File: rtl/run_gen_pkg.sv
// Shared encodings and default widths for the ones-run
// transmitter and its paired receiver.
package run_gen_pkg;

  localparam int LEN_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_GAP  = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

endpackage

// File: rtl/run_len_counter.sv
// Loadable down-counter for the run engine.
// last flags the final 1 of a run.
module run_len_counter #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [LEN_W-1:0] len,
  output logic             last
);

  logic [LEN_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst)
      cnt <= '0;
    else if (load)
      cnt <= len;
    else if (dec && cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign last = (cnt == LEN_W'(1));

endmodule

// File: rtl/run_pattern_gen.sv
// Ones-run transmitter: L ones then a single 0,
// with a one-entry pending slot for back-to-back runs.
module run_pattern_gen
  import run_gen_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             ready,
  output logic             x,
  output logic             done,
  output logic             busy,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] runs_sent
);

  state_t           st_q, st_d;
  logic             pend_v_q, pend_v_d;
  logic [LEN_W-1:0] pend_q, pend_d;
  logic [LEN_W-1:0] load_len;
  logic             load;
  logic             last;
  logic             accept;
  logic             x_q, done_q, busy_q;
  logic [CNT_W-1:0] runs_q;

  assign ready  = ~pend_v_q;
  assign accept = start & ready;

  run_len_counter #(
    .LEN_W(LEN_W)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .load(load),
    .dec (st_q == ST_RUN),
    .len (load_len),
    .last(last)
  );

  always_comb begin
    st_d     = st_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    load     = 1'b0;
    load_len = len;
    case (st_q)
      ST_IDLE: begin
        if (accept) load = 1'b1;
      end
      ST_RUN: begin
        if (accept) begin
          pend_v_d = 1'b1;
          pend_d   = len;
        end
        if (last) st_d = ST_GAP;
      end
      ST_GAP: begin
        if (pend_v_q) begin
          load     = 1'b1;
          load_len = pend_q;
          pend_v_d = 1'b0;
        end else if (accept) begin
          load = 1'b1;
        end else begin
          st_d = ST_IDLE;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    // a zero-length run goes straight to its separator
    if (load)
      st_d = (load_len != '0) ? ST_RUN : ST_GAP;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q     <= ST_IDLE;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
      x_q      <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      runs_q   <= '0;
    end else begin
      st_q     <= st_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      x_q      <= (st_d == ST_RUN);
      done_q   <= (st_d == ST_GAP);
      busy_q   <= (st_d != ST_IDLE);
      if (st_q == ST_GAP)
        runs_q <= runs_q + 1'b1;
    end
  end

  assign x         = x_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign state     = st_q;
  assign runs_sent = runs_q;

endmodule

// File: tb/tb_run_pattern_gen.sv
// Randomized bench for run_pattern_gen against a
// bit-stream queue model of the ones-run protocol.
module tb_run_pattern_gen;

  localparam int LEN_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             ready, x, done, busy;
  logic [1:0]       state;
  logic [CNT_W-1:0] runs_sent;

  int checks = 0;
  int errors = 0;

  int               bits_m[$];
  int               pend_m[$];
  logic [CNT_W-1:0] runs_m;

  run_pattern_gen #(
    .LEN_W(LEN_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .ready    (ready),
    .x        (x),
    .done     (done),
    .busy     (busy),
    .state    (state),
    .runs_sent(runs_sent)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic expand(input int l);
    for (int i = 0; i < l; i++) bits_m.push_back(1);
    bits_m.push_back(0);
  endtask

  // one clock edge of the protocol, in stream terms
  task automatic model();
    bit rdy;
    if (!rst) begin
      bits_m.delete();
      pend_m.delete();
      runs_m = '0;
      return;
    end
    rdy = (pend_m.size() == 0);
    if (bits_m.size() > 0) begin
      if (bits_m.pop_front() == 0) runs_m = runs_m + 1'b1;
    end
    if (bits_m.size() == 0 && pend_m.size() > 0)
      expand(pend_m.pop_front());
    if (start && rdy) begin
      if (bits_m.size() == 0) expand(int'(len));
      else pend_m.push_back(int'(len));
    end
  endtask

  task automatic compare();
    logic       ex, ed, eb;
    logic [1:0] es;
    ex = 1'b0; ed = 1'b0; eb = 1'b0; es = 2'b00;
    if (bits_m.size() > 0) begin
      eb = 1'b1;
      ex = (bits_m[0] == 1);
      ed = (bits_m[0] == 0);
      es = ex ? 2'b01 : 2'b10;
    end
    chk("x", 32'(x), 32'(ex));
    chk("done", 32'(done), 32'(ed));
    chk("busy", 32'(busy), 32'(eb));
    chk("state", 32'(state), 32'(es));
    chk("ready", 32'(ready), 32'(pend_m.size() == 0));
    chk("runs_sent", 32'(runs_sent), 32'(runs_m));
  endtask

  task automatic step();
    @(posedge clk);
    model();
    #1;
    compare();
  endtask

  task automatic send(input int l);
    start = 1'b1;
    len   = LEN_W'(l);
    step();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    start = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    runs_m = '0;
    rst    = 1'b0;
    start  = 1'b1;
    len    = 4'd7;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    idle(2);

    send(3);
    idle(6);

    send(2);
    send(4);
    idle(10);

    send(2);
    send(4);
    send(7);
    idle(10);

    send(0);
    idle(3);
    send(15);
    idle(18);

    send(5);
    send(3);
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    idle(8);

    start = 1'b1;
    len   = 4'd1;
    for (int i = 0; i < 515; i++) step();
    idle(4);

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 1) == 1);
      len   = LEN_W'($urandom);
      if ($urandom_range(0, 9) == 0) len = '0;
      rst   = ($urandom_range(0, 249) != 0);
      step();
    end
    rst = 1'b1;
    idle(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
